// File: rtl/store_fsm.sv
// rtl/store_fsm.sv - STORE micro-sequencer: Rj->MAR, Ri->MDR, memory write, wait MFC (optional STORE_TIMEOUT_EN)
module store_fsm #(
    parameter int SEL_W          = 6,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MFC,
    input  logic [SEL_W-1:0] Ri,
    input  logic [SEL_W-1:0] Rj,
    output logic             R0_read,
    output logic             R1_read,
    output logic             R2_read,
    output logic             R3_read,
    output logic             P0_read,
    output logic             MAR_write,
    output logic             MAR_mem_read,
    output logic             MDR_write,
    output logic             MDR_mem_read,
    output logic             MEM_EN,
    output logic             MEM_RW,
    output logic             done,
    output logic             busy,
    output logic             bad_sel,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [SEL_W-1:0] LP_MAX_SEL = SEL_W'(4);

    // Timeout limit outside 1..255 cannot be represented by the 8-bit counter.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("store_fsm: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t           r_state;
    state_t           w_next;
    logic [SEL_W-1:0] r_ri;
    logic [SEL_W-1:0] r_rj;
    logic             r_bad;
    logic             w_launch;
    logic             w_bad_in;
    logic             w_timeout;
    logic [4:0]       w_rd;

    // One-hot register read strobe for a selector: {R0,R1,R2,R3,P0}.
    function automatic logic [4:0] f_onehot(input logic [SEL_W-1:0] s);
        logic [4:0] v;
        v = 5'b00000;
        case (s)
            SEL_W'(0): v = 5'b10000;
            SEL_W'(1): v = 5'b01000;
            SEL_W'(2): v = 5'b00100;
            SEL_W'(3): v = 5'b00010;
            SEL_W'(4): v = 5'b00001;
            default:   v = 5'b00000;
        endcase
        return v;
    endfunction

    assign w_launch = (r_state == S_IDLE) && start;
    assign w_bad_in = (Ri > LP_MAX_SEL) || (Rj > LP_MAX_SEL);

`ifdef STORE_TIMEOUT_EN
    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    assign w_timeout = (r_state == S_WAIT) && !MFC && (r_cnt == LP_LIMIT);

    // WAIT-cycle counter: cleared while in WRITE so it starts at 0 on WAIT entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_WRITE) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_WAIT && !MFC) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Error cause flag: set when WAIT gives up, cleared on each new launch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_launch) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
`else
    logic r_err;

    assign w_timeout = 1'b0;
    assign r_err     = 1'b0;
`endif

    // State register plus selector/cause capture on the edge that leaves IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ri    <= '0;
            r_rj    <= '0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_ri  <= Ri;
                r_rj  <= Rj;
                r_bad <= w_bad_in;
            end
        end
    end

    // Next-state logic; MFC is only looked at in WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_bad_in ? S_DONE : S_ADDR;
            S_ADDR:  w_next = S_DATA;
            S_DATA:  w_next = S_WRITE;
            S_WRITE: w_next = S_WAIT;
            S_WAIT:  if (MFC || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore output decode from the registered state; everything forced low while in reset.
    always_comb begin
        w_rd         = 5'b00000;
        MAR_write    = 1'b0;
        MAR_mem_read = 1'b0;
        MDR_write    = 1'b0;
        MDR_mem_read = 1'b0;
        MEM_EN       = 1'b0;
        MEM_RW       = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;
        bad_sel      = 1'b0;
        err          = 1'b0;
        if (reset) begin
            busy = (r_state != S_IDLE);
            case (r_state)
                S_ADDR: begin
                    w_rd      = f_onehot(r_rj);
                    MAR_write = 1'b1;
                end
                S_DATA: begin
                    w_rd      = f_onehot(r_ri);
                    MDR_write = 1'b1;
                end
                S_WRITE, S_WAIT: begin
                    MAR_mem_read = 1'b1;
                    MDR_mem_read = 1'b1;
                    MEM_EN       = 1'b1;
                end
                S_DONE: begin
                    done    = 1'b1;
                    bad_sel = r_bad;
                    err     = r_err;
                end
                default: ;
            endcase
        end
    end

    assign R0_read = w_rd[4];
    assign R1_read = w_rd[3];
    assign R2_read = w_rd[2];
    assign R3_read = w_rd[1];
    assign P0_read = w_rd[0];

endmodule

// File: tb/tb_store_fsm.sv
// tb/tb_store_fsm.sv - directed scoreboard bench for store_fsm
module tb_store_fsm;

    localparam int SEL_W = 6;

`ifdef STORE_TIMEOUT_EN
    localparam int LONG_WAIT = 3;
`else
    localparam int LONG_WAIT = 7;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             MFC;
    logic [SEL_W-1:0] Ri;
    logic [SEL_W-1:0] Rj;
    logic R0_read, R1_read, R2_read, R3_read, P0_read;
    logic MAR_write, MAR_mem_read, MDR_write, MDR_mem_read;
    logic MEM_EN, MEM_RW, done, busy, bad_sel, err;

    int checks   = 0;
    int failures = 0;

    logic [14:0] q_exp[$];

    store_fsm #(.SEL_W(SEL_W), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .MFC(MFC), .Ri(Ri), .Rj(Rj),
        .R0_read(R0_read), .R1_read(R1_read), .R2_read(R2_read), .R3_read(R3_read), .P0_read(P0_read),
        .MAR_write(MAR_write), .MAR_mem_read(MAR_mem_read), .MDR_write(MDR_write),
        .MDR_mem_read(MDR_mem_read), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW),
        .done(done), .busy(busy), .bad_sel(bad_sel), .err(err)
    );

    always #5 clk = ~clk;

    // Observed vector: {R0,R1,R2,R3,P0, MAR_w, MAR_mr, MDR_w, MDR_mr, EN, RW, done, busy, bad, err}
    function automatic logic [14:0] obs();
        return {R0_read, R1_read, R2_read, R3_read, P0_read, MAR_write, MAR_mem_read,
                MDR_write, MDR_mem_read, MEM_EN, MEM_RW, done, busy, bad_sel, err};
    endfunction

    function automatic logic [4:0] rd(input int s);
        logic [4:0] b;
        b = 5'b10000;
        return b >> s;
    endfunction

    function automatic logic [14:0] e_addr(input int rj);
        return {rd(rj), 10'b1000000100};
    endfunction

    function automatic logic [14:0] e_data(input int ri);
        return {rd(ri), 10'b0010000100};
    endfunction

    function automatic logic [14:0] e_mem();
        return {5'b00000, 10'b0101100100};
    endfunction

    function automatic logic [14:0] e_done(input logic bad, input logic er);
        return {5'b00000, 8'b00000011, bad, er};
    endfunction

    function automatic logic [14:0] e_idle();
        return 15'd0;
    endfunction

    // Push expectation for the cycle after the next edge, advance, then pop and compare.
    task automatic step(input string tag, input logic [14:0] exp);
        logic [14:0] e;
        q_exp.push_back(exp);
        @(posedge clk);
        #1;
        checks++;
        if (q_exp.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs());
        end else begin
            e = q_exp.pop_front();
            assert (obs() === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs(), e);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; MFC = 1'b0; Ri = '0; Rj = '0;
        step("reset0", e_idle());
        step("reset1", e_idle());
        reset = 1'b1;
        step("idle", e_idle());

        // Basic store Ri=2 Rj=4, MFC on first WAIT cycle
        Ri = 6'd2; Rj = 6'd4; start = 1'b1;
        step("t1_addr", e_addr(4));
        start = 1'b0;
        step("t1_data", e_data(2));
        step("t1_write", e_mem());
        step("t1_wait", e_mem());
        MFC = 1'b1;
        step("t1_done", e_done(1'b0, 1'b0));
        MFC = 1'b0;
        step("t1_idle", e_idle());

        // MFC only during WRITE is ignored; then long wait
        Ri = 6'd3; Rj = 6'd0; start = 1'b1;
        step("t2_addr", e_addr(0));
        start = 1'b0;
        step("t2_data", e_data(3));
        step("t2_write", e_mem());
        MFC = 1'b1;
        step("t2_wait1", e_mem());
        MFC = 1'b0;
        for (int i = 2; i <= LONG_WAIT + 1; i++) begin
            step($sformatf("t2_wait%0d", i), e_mem());
        end
        MFC = 1'b1;
        step("t2_done", e_done(1'b0, 1'b0));
        MFC = 1'b0;
        step("t2_idle", e_idle());
        step("t2_idle2", e_idle());

        // Ri change during ADDR ignored; start during WAIT ignored
        Ri = 6'd1; Rj = 6'd0; start = 1'b1;
        step("t3_addr", e_addr(0));
        start = 1'b0; Ri = 6'd3;
        step("t3_data", e_data(1));
        step("t3_write", e_mem());
        step("t3_wait1", e_mem());
        start = 1'b1;
        step("t3_wait2", e_mem());
        start = 1'b0; MFC = 1'b1;
        step("t3_done", e_done(1'b0, 1'b0));
        MFC = 1'b0;
        step("t3_idle", e_idle());
        step("t3_idle2", e_idle());

        // Bad selectors go straight to DONE
        Ri = 6'd0; Rj = 6'd5; start = 1'b1;
        step("t4_bad_rj", e_done(1'b1, 1'b0));
        start = 1'b0;
        step("t4_idle", e_idle());
        Ri = 6'd63; Rj = 6'd1; start = 1'b1;
        step("t4_bad_ri", e_done(1'b1, 1'b0));
        start = 1'b0;
        step("t4_idle2", e_idle());

        // Reset during WAIT, then a fresh store with Ri==Rj
        Ri = 6'd3; Rj = 6'd1; start = 1'b1;
        step("t5_addr", e_addr(1));
        start = 1'b0;
        step("t5_data", e_data(3));
        step("t5_write", e_mem());
        step("t5_wait", e_mem());
        reset = 1'b0;
        step("t5_rst", e_idle());
        reset = 1'b1;
        step("t5_idle", e_idle());
        Ri = 6'd2; Rj = 6'd2; start = 1'b1;
        step("t5b_addr", e_addr(2));
        start = 1'b0;
        step("t5b_data", e_data(2));
        step("t5b_write", e_mem());
        MFC = 1'b1;
        step("t5b_wait", e_mem());
        step("t5b_done", e_done(1'b0, 1'b0));
        MFC = 1'b0;
        step("t5b_idle", e_idle());

        // Back-to-back with start held through DONE
        Ri = 6'd4; Rj = 6'd3; start = 1'b1; MFC = 1'b1;
        step("t6_addr", e_addr(3));
        step("t6_data", e_data(4));
        step("t6_write", e_mem());
        step("t6_wait", e_mem());
        step("t6_done", e_done(1'b0, 1'b0));
        step("t6_idle", e_idle());
        step("t6_addr2", e_addr(3));
        start = 1'b0;
        step("t6_data2", e_data(4));
        step("t6_write2", e_mem());
        step("t6_wait2", e_mem());
        step("t6_done2", e_done(1'b0, 1'b0));
        MFC = 1'b0;
        step("t6_idle2", e_idle());

`ifdef STORE_TIMEOUT_EN
        // Timeout with limit 4: four WAIT cycles then DONE with err
        Ri = 6'd0; Rj = 6'd1; start = 1'b1;
        step("t7_addr", e_addr(1));
        start = 1'b0;
        step("t7_data", e_data(0));
        step("t7_write", e_mem());
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("t7_wait%0d", i), e_mem());
        end
        step("t7_done_err", e_done(1'b0, 1'b1));
        step("t7_idle", e_idle());
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so a stalled run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
